// File: rtl/addsub_fu.sv
// Add/subtract functional unit for a reservation-station backend.
// One operation in flight. An add takes one cycle and a subtract takes two,
// because the extra INV cycle inverts b. The result is held until the CDB
// takes it.
module addsub_fu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic             out_ovf,
  input  logic             flush,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StInv, StExec, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // Handshake and adder. When op_q is set, b_q already holds ~b, so op_q is the carry-in.
  always_comb begin
    in_ready = ~flush & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
    accept   = in_valid & in_ready;
    sum      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, op_q};
    ovf      = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Outputs come straight from state and result registers.
  always_comb begin
    out_valid  = (state_q == StDone);
    busy       = (state_q != StIdle);
    out_result = result_q;
    out_tag    = tag_q;
    out_carry  = carry_q;
    out_ovf    = ovf_q;
  end

  // FSM and datapath registers. Flush wins over both accept and retire.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
    end else if (accept) begin
      // Accept happens from IDLE, or from DONE on the same edge as the retire.
      a_q     <= in_a;
      b_q     <= in_b;
      op_q    <= in_op;
      tag_q   <= in_tag;
      state_q <= in_op ? StInv : StExec;
    end else begin
      case (state_q)
        StInv: begin
          b_q     <= ~b_q;
          state_q <= StExec;
        end
        StExec: begin
          result_q <= sum[WIDTH-1:0];
          carry_q  <= sum[WIDTH];
          ovf_q    <= ovf;
          state_q  <= StDone;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_fu.sv
// Self-checking bench for addsub_fu (WIDTH=32, TAG_W=4).
// Inputs are driven and outputs are sampled on the falling edge.
module tb_addsub_fu;
  localparam int unsigned W = 32;
  localparam int unsigned T = 4;

  logic         clk = 1'b0;
  logic         nRST;
  logic         in_valid;
  logic         in_ready;
  logic         in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [T-1:0] in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [T-1:0] out_tag;
  logic         out_carry;
  logic         out_ovf;
  logic         flush;
  logic         busy;

  int total = 0;
  int bad   = 0;

  addsub_fu #(.WIDTH(W), .TAG_W(T)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .flush     (flush),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [T-1:0] tag;
    logic [W-1:0] res;
    logic         carry;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model using wide signed and unsigned arithmetic.
  function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c, output logic o);
    longint ua, ub, sa, sb, full, sr;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op) begin
      full = ua + ub;
      c    = (full >= 64'sd4294967296);
      sr   = sa + sb;
    end else begin
      full = ua - ub;
      c    = (ua >= ub);
      sr   = sa - sb;
    end
    r = full[W-1:0];
    o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  // Called between a falling and a rising edge. Returns on the falling edge after the accept edge.
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [T-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    #1 check("in_ready_at_issue", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen. The wait is bounded.
  task automatic wait_done(output int k);
    k = 0;
    while (!out_valid && k < 8) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_retire", out_valid, 0);
  endtask

  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [T-1:0] tag, input int hold);
    logic [W-1:0] r;
    logic         c, o;
    int           k;
    model(op, a, b, r, c, o);
    issue(op, a, b, tag);
    wait_done(k);
    check("latency", k, op ? 2 : 1);
    check("result", out_result, r);
    check("tag", out_tag, tag);
    check("carry", out_carry, c);
    check("ovf", out_ovf, o);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, r);
      check("hold_in_ready", in_ready, 0);
    end
    retire();
  endtask

  initial begin
    int k;
    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 4'd2, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 4'd9, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 4'd1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd7, 32'h8000_0000, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'd15, 32'h0000_0000, 1'b1, 1'b0};

    nRST = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0; flush = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", out_result, 0);
    check("rst_tag", out_tag, 0);
    check("rst_flags", {out_carry, out_ovf}, 0);
    @(negedge clk);
    nRST = 1'b1;
    #1 check("in_ready_after_reset", in_ready, 1);
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_done(k);
      check("vec_latency", k, vecs[i].op ? 2 : 1);
      check("vec_result", out_result, vecs[i].res);
      check("vec_tag", out_tag, vecs[i].tag);
      check("vec_carry", out_carry, vecs[i].carry);
      check("vec_ovf", out_ovf, vecs[i].ovf);
      retire();
    end

    // Back-pressure: the result stays put for 5 cycles, then is retired
    issue(1'b0, 32'hFFFF_FFFF, 32'h1, 4'd3);
    wait_done(k);
    check("bp_latency", k, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_result", out_result, 0);
      check("bp_carry", out_carry, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("bp_in_ready_on_retire", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_retired", out_valid, 0);
    check("bp_idle", busy, 0);

    // Back-to-back: retire and accept on the same edge
    issue(1'b0, 32'd3, 32'd4, 4'd1);
    wait_done(k);
    check("b2b_first", out_result, 7);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 1'b0; in_a = 32'd1; in_b = 32'd1; in_tag = 4'd5;
    #1 check("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_gap_valid", out_valid, 0);
    check("b2b_gap_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_valid", out_valid, 1);
    check("b2b_result", out_result, 2);
    check("b2b_tag", out_tag, 5);
    retire();

    // Flush while in INV
    issue(1'b1, 32'd10, 32'd3, 4'd6);
    check("inv_busy", busy, 1);
    flush = 1'b1; in_valid = 1'b1; in_op = 1'b0;
    #1 check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_inv_busy", busy, 0);
    check("flush_inv_valid", out_valid, 0);

    // Flush while in DONE, with an issue and a retire both offered
    issue(1'b0, 32'd20, 32'd22, 4'd8);
    wait_done(k);
    check("pre_flush_done", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("flush_done_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_done_busy", busy, 0);
    check("flush_done_valid", out_valid, 0);

    // Asynchronous reset during EXEC
    issue(1'b0, 32'd9, 32'd9, 4'd3);
    #2 nRST = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_result", out_result, 0);
    check("arst_tag", out_tag, 0);
    check("arst_flags", {out_carry, out_ovf}, 0);
    @(negedge clk);
    nRST = 1'b1;
    #1 check("arst_in_ready", in_ready, 1);
    @(negedge clk);

    // Random operations, each held for a random number of cycles before retire
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) ra = 32'h8000_0000;
      if (i % 8 == 1) rb = 32'h8000_0000;
      run_op(1'($urandom_range(1, 0)), ra, rb, 4'($urandom_range(15, 0)),
             int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
